// File: rtl/shared_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// shared_mem_arbiter_pkg
// Shared definitions for the shared-memory arbiter and the core datapath:
//   - arb_state_t        : arbiter FSM state encoding
//   - DEFAULT_ADDR_WIDTH : default data-memory address width
//   - DEFAULT_DATA_WIDTH : default data-memory word width
// -----------------------------------------------------------------------------
package shared_mem_arbiter_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 12;
  localparam int unsigned DEFAULT_DATA_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Scans the request vector upward from
// the priority pointer, wrapping modulo `cores`, and reports the first hit.
// Ports:
//   i_req    : per-core request vector
//   i_ptr    : index with highest priority this round
//   o_onehot : one-hot winner (all zero when nothing requests)
//   o_idx    : winner index (0 when nothing requests)
//   o_any    : at least one request is present
// -----------------------------------------------------------------------------
module rr_picker #(
  parameter int unsigned cores = 4,
  localparam int unsigned PW   = $clog2(cores)
) (
  input  logic [cores-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [cores-1:0] o_onehot,
  output logic [PW-1:0]    o_idx,
  output logic             o_any
);

  int unsigned w_pos;
  logic        w_found;

  assign o_any = |i_req;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    w_pos    = 0;
    for (int unsigned k = 0; k < cores; k++) begin
      // ptr < cores, so a single conditional subtract implements the wrap
      w_pos = 32'(i_ptr) + k;
      if (w_pos >= cores) begin
        w_pos = w_pos - cores;
      end
      if (!w_found && i_req[PW'(w_pos)]) begin
        w_found                = 1'b1;
        o_idx                  = PW'(w_pos);
        o_onehot[PW'(w_pos)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_mem_arbiter.sv
// -----------------------------------------------------------------------------
// shared_mem_arbiter
// Round-robin arbiter sharing one single-port data memory among `cores`
// cores. One transaction at a time: grant, one strobe cycle, fixed memory
// latency wait, then a one-cycle done pulse with read data broadcast.
// Ports:
//   clk, rst           : clock, synchronous active-low reset
//   req, wrReq         : per-core request level and direction (1 = write)
//   addrIn, dataIn     : packed per-core address / write data
//   grant, done        : one-hot owner / one-cycle completion pulse
//   dataOut            : read data, valid while done is high
//   busy               : arbiter not idle
//   memAddr/memDataOut : memory address / write data
//   memRdEn/memWrEn    : memory strobes (mutually exclusive)
//   memDataIn          : memory read data
// -----------------------------------------------------------------------------
module shared_mem_arbiter
  import shared_mem_arbiter_pkg::*;
#(
  parameter int unsigned cores      = 4,
  parameter int unsigned addrWidth  = DEFAULT_ADDR_WIDTH,
  parameter int unsigned dataWidth  = DEFAULT_DATA_WIDTH,
  parameter int unsigned memLatency = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [cores-1:0]           req,
  input  logic [cores-1:0]           wrReq,
  input  logic [cores*addrWidth-1:0] addrIn,
  input  logic [cores*dataWidth-1:0] dataIn,
  output logic [cores-1:0]           grant,
  output logic [cores-1:0]           done,
  output logic [dataWidth-1:0]       dataOut,
  output logic                       busy,
  output logic [addrWidth-1:0]       memAddr,
  output logic [dataWidth-1:0]       memDataOut,
  output logic                       memRdEn,
  output logic                       memWrEn,
  input  logic [dataWidth-1:0]       memDataIn
);

  localparam int unsigned PW = $clog2(cores);
  localparam int unsigned CW = $clog2(memLatency + 1);

  arb_state_t           r_state;
  arb_state_t           w_next_state;
  logic [PW-1:0]        r_ptr;
  logic [PW-1:0]        r_idx;
  logic                 r_isWrite;
  logic [CW-1:0]        r_cnt;
  logic [cores-1:0]     r_grant;
  logic [cores-1:0]     r_done;
  logic [dataWidth-1:0] r_dataOut;
  logic [addrWidth-1:0] r_memAddr;
  logic [dataWidth-1:0] r_memDataOut;
  logic                 r_memRdEn;
  logic                 r_memWrEn;

  logic [cores-1:0]     w_onehot;
  logic [PW-1:0]        w_idx;
  logic                 w_any;
  logic [addrWidth-1:0] w_addr [cores];
  logic [dataWidth-1:0] w_data [cores];

  for (genvar g = 0; g < cores; g++) begin : g_unpack
    assign w_addr[g] = addrIn[g*addrWidth +: addrWidth];
    assign w_data[g] = dataIn[g*dataWidth +: dataWidth];
  end

  rr_picker #(
    .cores (cores)
  ) u_picker (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next_state = ACCESS;
      ACCESS:  w_next_state = WAIT;
      WAIT:    if (r_cnt == CW'(1)) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr        <= '0;
      r_idx        <= '0;
      r_isWrite    <= 1'b0;
      r_cnt        <= '0;
      r_grant      <= '0;
      r_done       <= '0;
      r_dataOut    <= '0;
      r_memAddr    <= '0;
      r_memDataOut <= '0;
      r_memRdEn    <= 1'b0;
      r_memWrEn    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant      <= w_onehot;
            r_idx        <= w_idx;
            r_isWrite    <= wrReq[w_idx];
            r_memAddr    <= w_addr[w_idx];
            r_memDataOut <= w_data[w_idx];
            r_memRdEn    <= ~wrReq[w_idx];
            r_memWrEn    <= wrReq[w_idx];
            r_cnt        <= CW'(memLatency);
          end
        end
        ACCESS: begin
          r_memRdEn <= 1'b0;
          r_memWrEn <= 1'b0;
        end
        WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          // count of 1 marks the cycle the memory presents read data
          if (r_cnt == CW'(1)) begin
            r_done <= r_grant;
            if (!r_isWrite) begin
              r_dataOut <= memDataIn;
            end
          end
        end
        DONE: begin
          r_done  <= '0;
          r_grant <= '0;
          r_ptr   <= (r_idx == PW'(cores - 1)) ? '0 : r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign grant      = r_grant;
  assign done       = r_done;
  assign dataOut    = r_dataOut;
  assign busy       = (r_state != IDLE);
  assign memAddr    = r_memAddr;
  assign memDataOut = r_memDataOut;
  assign memRdEn    = r_memRdEn;
  assign memWrEn    = r_memWrEn;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_mem_arbiter
// Randomized bench for shared_mem_arbiter. A transaction-level model decides,
// per cycle, which core wins and when the strobe and done must appear; those
// expectations go into queues that a negedge monitor drains as the DUT
// presents strobes and done pulses.
// -----------------------------------------------------------------------------
module tb_shared_mem_arbiter;

  localparam int NC = 4;
  localparam int AW = 12;
  localparam int DW = 12;
  localparam int L  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NC-1:0]    req, wrReq;
  logic [NC*AW-1:0] addrIn;
  logic [NC*DW-1:0] dataIn;
  logic [NC-1:0]    grant, done;
  logic [DW-1:0]    dataOut;
  logic             busy;
  logic [AW-1:0]    memAddr;
  logic [DW-1:0]    memDataOut;
  logic             memRdEn, memWrEn;
  logic [DW-1:0]    memDataIn;

  always #5 clk = ~clk;

  shared_mem_arbiter #(
    .cores      (NC),
    .addrWidth  (AW),
    .dataWidth  (DW),
    .memLatency (L)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .wrReq      (wrReq),
    .addrIn     (addrIn),
    .dataIn     (dataIn),
    .grant      (grant),
    .done       (done),
    .dataOut    (dataOut),
    .busy       (busy),
    .memAddr    (memAddr),
    .memDataOut (memDataOut),
    .memRdEn    (memRdEn),
    .memWrEn    (memWrEn),
    .memDataIn  (memDataIn)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return DW'((32'(a) * 37 + 11) ^ 32'h5A3);
  endfunction

  // Memory: writes on the strobe edge, read data appears exactly L cycles
  // after the read strobe cycle and is random junk otherwise.
  logic [DW-1:0] phys [4096];
  bit            phys_v [4096];
  logic          pv [L];
  logic [DW-1:0] pd [L];
  logic [DW-1:0] junk;

  always @(posedge clk) begin
    junk <= DW'($urandom);
    if (memWrEn === 1'b1) begin
      phys[memAddr]   <= memDataOut;
      phys_v[memAddr] <= 1'b1;
    end
    pv[0] <= (memRdEn === 1'b1);
    pd[0] <= phys_v[memAddr] ? phys[memAddr] : init_val(memAddr);
    for (int k = 1; k < L; k++) begin
      pv[k] <= pv[k-1];
      pd[k] <= pd[k-1];
    end
  end
  assign memDataIn = pv[L-1] ? pd[L-1] : junk;

  // ---------------------------------------------------------------- model --
  typedef struct {
    int            cyc;
    int            core;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            wr;
  } acc_t;

  typedef struct {
    int            cyc;
    int            core;
    logic [DW-1:0] dout;
  } cmp_t;

  acc_t acc_q[$];
  cmp_t cmp_q[$];

  bit            pending [NC];
  bit            active  [NC];
  bit            dropped [NC];
  logic [AW-1:0] p_addr  [NC];
  logic [DW-1:0] p_data  [NC];
  bit            p_wr    [NC];
  int            done_cyc[NC];

  logic [DW-1:0] ref_mem [4096];
  bit            ref_v   [4096];

  int            ptr_m     = 0;
  int            next_idle = 0;
  int            busy_lo   = 1;
  int            busy_hi   = 0;
  int            gcore     = 0;
  int            last_rst  = -10;
  logic [DW-1:0] exp_dout  = '0;
  bit            started   = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic new_req(input int i);
    pending[i] = 1'b1;
    p_addr[i]  = ($urandom_range(1) == 1) ? AW'($urandom_range(31)) : AW'($urandom);
    p_data[i]  = DW'($urandom);
    p_wr[i]    = ($urandom_range(1) == 1);
  endtask

  function automatic bit any_pending();
    for (int i = 0; i < NC; i++) if (pending[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic decide();
    int w;
    int idx;
    w = -1;
    for (int k = 0; k < NC; k++) begin
      idx = (ptr_m + k) % NC;
      if (w < 0 && pending[idx]) w = idx;
    end
    if (w < 0) return;
    acc_q.push_back('{cyc + 1, w, p_addr[w], p_data[w], p_wr[w]});
    if (!p_wr[w]) begin
      exp_dout = ref_v[p_addr[w]] ? ref_mem[p_addr[w]] : init_val(p_addr[w]);
    end else begin
      ref_mem[p_addr[w]] = p_data[w];
      ref_v[p_addr[w]]   = 1'b1;
    end
    cmp_q.push_back('{cyc + 2 + L, w, exp_dout});
    busy_lo     = cyc + 1;
    busy_hi     = cyc + 2 + L;
    next_idle   = cyc + 3 + L;
    gcore       = w;
    ptr_m       = (w + 1) % NC;
    pending[w]  = 1'b0;
    active[w]   = 1'b1;
    dropped[w]  = 1'b0;
    done_cyc[w] = cyc + 2 + L;
  endtask

  // One clock of stimulus: inputs change 2 time units after the rising edge.
  task automatic cycle_drive(input int p_new, input bit do_rst);
    @(posedge clk);
    #2;
    for (int i = 0; i < NC; i++) begin
      if (active[i] && done_cyc[i] == cyc) active[i] = 1'b0;
      if (active[i] && !dropped[i] && $urandom_range(7) == 0) dropped[i] = 1'b1;
      if (!do_rst && !pending[i] && !active[i] && done_cyc[i] != cyc &&
          int'($urandom_range(99)) < p_new) new_req(i);
    end
    if (do_rst) begin
      for (int i = 0; i < NC; i++) begin
        pending[i] = 1'b0;
        active[i]  = 1'b0;
      end
      acc_q.delete();
      cmp_q.delete();
      ptr_m     = 0;
      next_idle = cyc + 1;
      busy_lo   = 1;
      busy_hi   = 0;
      exp_dout  = '0;
      last_rst  = cyc;
    end
    rst = !do_rst;
    for (int i = 0; i < NC; i++) begin
      req[i]              = pending[i] | (active[i] & !dropped[i]);
      wrReq[i]            = pending[i] ? p_wr[i] : ($urandom_range(1) == 1);
      addrIn[i*AW +: AW]  = pending[i] ? p_addr[i] : AW'($urandom);
      dataIn[i*DW +: DW]  = pending[i] ? p_data[i] : DW'($urandom);
    end
    if (!do_rst && cyc >= next_idle) decide();
  endtask

  // -------------------------------------------------------------- monitor --
  initial begin
    acc_t          a;
    cmp_t          d;
    logic [NC-1:0] eg;
    bit            eb;
    forever begin
      @(negedge clk);
      if (started && rst === 1'b1) begin
        if (last_rst == cyc - 1) begin
          chk("reset_outputs",
              64'({grant, done, dataOut, busy, memAddr, memDataOut, memRdEn, memWrEn}), 64'd0);
        end
        eb = (cyc >= busy_lo && cyc <= busy_hi);
        eg = eb ? (NC'(1) << gcore) : '0;
        chk("busy", 64'(busy), 64'(eb));
        chk("grant", 64'(grant), 64'(eg));
        chk("strobe_exclusive", 64'(memRdEn & memWrEn), 64'd0);

        while (acc_q.size() > 0 && acc_q[0].cyc < cyc) begin
          a = acc_q.pop_front();
          chk("strobe_missing_cycle", 64'(cyc), 64'(a.cyc));
        end
        if (memRdEn || memWrEn) begin
          if (acc_q.size() == 0) begin
            chk("unexpected_strobe", 64'({memRdEn, memWrEn}), 64'd0);
          end else begin
            a = acc_q.pop_front();
            chk("strobe_cycle", 64'(cyc), 64'(a.cyc));
            chk("memAddr", 64'(memAddr), 64'(a.addr));
            chk("memDataOut", 64'(memDataOut), 64'(a.data));
            chk("memWrEn", 64'(memWrEn), 64'(a.wr));
            chk("memRdEn", 64'(memRdEn), 64'(!a.wr));
          end
        end

        while (cmp_q.size() > 0 && cmp_q[0].cyc < cyc) begin
          d = cmp_q.pop_front();
          chk("done_missing_cycle", 64'(cyc), 64'(d.cyc));
        end
        if (done != '0) begin
          if (cmp_q.size() == 0) begin
            chk("unexpected_done", 64'(done), 64'd0);
          end else begin
            d = cmp_q.pop_front();
            chk("done_cycle", 64'(cyc), 64'(d.cyc));
            chk("done_onehot", 64'(done), 64'(NC'(1) << d.core));
            chk("dataOut", 64'(dataOut), 64'(d.dout));
          end
        end
      end
    end
  end

  // ------------------------------------------------------------- stimulus --
  initial begin
    bit reached;
    rst    = 1'b0;
    req    = '0;
    wrReq  = '0;
    addrIn = '0;
    dataIn = '0;
    for (int i = 0; i < NC; i++) begin
      pending[i]  = 1'b0;
      active[i]   = 1'b0;
      dropped[i]  = 1'b0;
      done_cyc[i] = -1;
    end

    cycle_drive(0, 1'b1);
    started = 1'b1;
    cycle_drive(0, 1'b1);

    // heavy contention: every idle core re-requests almost immediately
    repeat (300) cycle_drive(95, 1'b0);
    // sparse traffic: lone requests, idle gaps, wrap-around of the pointer
    repeat (300) cycle_drive(15, 1'b0);

    // reset while a transaction sits in its latency wait
    reached = 1'b0;
    for (int k = 0; k < 200 && !reached; k++) begin
      if ((cyc + 1 >= busy_lo + 1) && (cyc + 1 <= busy_hi - 1)) reached = 1'b1;
      else cycle_drive(60, 1'b0);
    end
    if (!reached) begin
      n_tests++;
      n_fail++;
      $display("FAIL reach_wait: got no wait state, want one within 200 cycles");
    end
    cycle_drive(0, 1'b1);

    // cores 0 and 1 together right after reset: pointer restarts at 0
    new_req(0);
    new_req(1);
    cycle_drive(0, 1'b0);
    repeat (20) cycle_drive(0, 1'b0);

    repeat (300) cycle_drive(40, 1'b0);

    for (int k = 0; k < 100 && (acc_q.size() != 0 || cmp_q.size() != 0 || any_pending()); k++)
      cycle_drive(0, 1'b0);
    chk("drain", 64'(acc_q.size() + cmp_q.size()), 64'd0);
    cycle_drive(0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
